// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRA/ROR/SRL) with a global valid/ready stall.
// Define SHIFT_PIPE_CARRY_EN to add the registered out_carry output.
module shift_pipe #(
    parameter int WIDTH            = 16,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_zero,
`ifdef SHIFT_PIPE_CARRY_EN
    output logic                     out_carry,
`endif
    output logic                     out_neg
);

    localparam int SHW = $clog2(WIDTH);
    localparam int LAT = (SHW + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_SRL = 2'b11;

    // Stage registers; index s holds the result of level group s.
    logic [LAT-1:0]            vld_q,   vld_d;
    logic [LAT-1:0][WIDTH-1:0] data_q,  data_d;
    logic [LAT-1:0][SHW-1:0]   shamt_q, shamt_d;
    logic [LAT-1:0][1:0]       mode_q,  mode_d;
    logic [LAT-1:0]            sign_q,  sign_d;

    // Stage inputs: entry 0 is the input port, entry s is stage register s-1.
    logic [LAT:0]              v_in;
    logic [LAT:0][WIDTH-1:0]   d_in;
    logic [LAT:0][SHW-1:0]     sa_in;
    logic [LAT:0][1:0]         md_in;
    logic [LAT:0]              sg_in;

    logic [WIDTH-1:0]          lv_d;
    logic [SHW-1:0]            lv_sa;
    logic [1:0]                lv_md;
    logic                      lv_sg;
    logic                      stall;

    assign v_in  = {vld_q, in_valid};
    assign d_in  = {data_q, in_data};
    assign sa_in = {shamt_q, in_shamt};
    assign md_in = {mode_q, in_mode};
    assign sg_in = {sign_q, in_data[WIDTH-1]};

`ifdef SHIFT_PIPE_CARRY_EN
    localparam logic [WIDTH-1:0] LSB1 = WIDTH'(1);
    logic [LAT-1:0]            carry_q, carry_d;
    logic [LAT:0]              c_in;
    logic                      lv_c;
    assign c_in = {carry_q, 1'b0};
`endif

    assign stall    = vld_q[LAT-1] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        vld_d   = '0;
        data_d  = '0;
        shamt_d = '0;
        mode_d  = '0;
        sign_d  = '0;
        lv_d    = '0;
        lv_sa   = '0;
        lv_md   = '0;
        lv_sg   = 1'b0;
`ifdef SHIFT_PIPE_CARRY_EN
        carry_d = '0;
        lv_c    = 1'b0;
`endif
        for (int s = 0; s < LAT; s++) begin
            lv_d  = d_in[s];
            lv_sa = sa_in[s];
            lv_md = md_in[s];
            lv_sg = sg_in[s];
`ifdef SHIFT_PIPE_CARRY_EN
            lv_c  = c_in[s];
`endif
            for (int k = 0; k < SHW; k++) begin
                if ((k / LEVELS_PER_STAGE) == s && lv_sa[k]) begin
`ifdef SHIFT_PIPE_CARRY_EN
                    // SLL loses its top bits; every other mode's last casualty is bit 2^k-1.
                    if (lv_md == MODE_SLL)
                        lv_c = |((lv_d >> (WIDTH - (1 << k))) & LSB1);
                    else
                        lv_c = |((lv_d >> ((1 << k) - 1)) & LSB1);
`endif
                    case (lv_md)
                        MODE_SLL: lv_d = lv_d << (1 << k);
                        MODE_SRA: lv_d = (lv_d >> (1 << k)) |
                                         (lv_sg ? ~({WIDTH{1'b1}} >> (1 << k)) : '0);
                        MODE_ROR: lv_d = (lv_d >> (1 << k)) | (lv_d << (WIDTH - (1 << k)));
                        MODE_SRL: lv_d = lv_d >> (1 << k);
                        default:  lv_d = lv_d;
                    endcase
                end
            end
            vld_d[s]   = v_in[s];
            data_d[s]  = lv_d;
            shamt_d[s] = lv_sa;
            mode_d[s]  = lv_md;
            sign_d[s]  = lv_sg;
`ifdef SHIFT_PIPE_CARRY_EN
            carry_d[s] = lv_c;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= '0;
            sign_q  <= '0;
`ifdef SHIFT_PIPE_CARRY_EN
            carry_q <= '0;
`endif
        end else if (!stall) begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
`ifdef SHIFT_PIPE_CARRY_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign out_valid = v_in[LAT];
    assign out_data  = d_in[LAT];
    assign out_zero  = (d_in[LAT] == '0);
    assign out_neg   = d_in[LAT][WIDTH-1];
`ifdef SHIFT_PIPE_CARRY_EN
    assign out_carry = c_in[LAT];
`endif

    // Control fields of the output register are spent; nothing downstream reads them.
    logic tail_unused;
    assign tail_unused = ^{sa_in[LAT], md_in[LAT], sg_in[LAT]};

endmodule
